// File: rtl/mt_pkg.sv
// Shared barrel-processor definitions used by the scheduler, mt_pc and the pipeline registers.
package mt_pkg;
  localparam int NUM_THREADS  = 8;
  localparam int BITS_THREADS = $clog2(NUM_THREADS);

  typedef logic [BITS_THREADS-1:0] tid_t;
endpackage

// File: rtl/mt_thread_sched_rr_pick.sv
// Combinational round-robin finder: first set bit of req after ptr, wrapping back to ptr itself.
module rr_pick
  import mt_pkg::*;
#(
  parameter int NUM_THREADS  = mt_pkg::NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0]  req,
  input  logic [BITS_THREADS-1:0] ptr,
  output logic [BITS_THREADS-1:0] gnt_idx,
  output logic                    any
);

  logic [NUM_THREADS-1:0]  rot;
  logic [BITS_THREADS-1:0] start;
  logic [BITS_THREADS-1:0] off;

  // Rotate so bit 0 is the thread after ptr; ptr itself lands in the top bit and is checked last.
  always_comb begin
    start = ptr + BITS_THREADS'(1);
    rot   = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      rot[i] = req[start + BITS_THREADS'(i)];
    end
    off = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (rot[i]) off = BITS_THREADS'(i);
    end
    gnt_idx = start + off;
    any     = |req;
  end

endmodule

// File: rtl/mt_thread_sched.sv
// Fetch-stage thread scheduler: tracks the ready mask and issues runnable threads round-robin to mt_pc.
module mt_thread_sched
  import mt_pkg::*;
#(
  parameter int NUM_THREADS  = mt_pkg::NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_THREADS-1:0]  thread_en,
  input  logic                    halt_req,
  input  logic [BITS_THREADS-1:0] halt_tid,
  input  logic                    wake_req,
  input  logic [BITS_THREADS-1:0] wake_tid,
  input  logic                    stall,
  output logic [BITS_THREADS-1:0] tid,
  output logic                    tid_valid,
  output logic [NUM_THREADS-1:0]  ready_mask
);

  logic [NUM_THREADS-1:0]  ready_q;
  logic [NUM_THREADS-1:0]  halt_vec;
  logic [NUM_THREADS-1:0]  wake_vec;
  logic [NUM_THREADS-1:0]  ready_next;
  logic [NUM_THREADS-1:0]  eligible;
  logic [BITS_THREADS-1:0] gnt_idx;
  logic                    any;

  // Wake is OR-ed in after the halt is masked out, so a same-cycle wake always wins.
  always_comb begin
    halt_vec = '0;
    wake_vec = '0;
    if (halt_req) halt_vec[halt_tid] = 1'b1;
    if (wake_req) wake_vec[wake_tid] = 1'b1;
    ready_next = (ready_q & ~halt_vec) | wake_vec;
    eligible   = ready_next & thread_en;
  end

  rr_pick #(
    .NUM_THREADS (NUM_THREADS),
    .BITS_THREADS(BITS_THREADS)
  ) u_rr_pick (
    .req    (eligible),
    .ptr    (tid),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  // tid doubles as the round-robin pointer; starting at the last thread makes thread 0 the first pick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= '1;
      tid       <= BITS_THREADS'(NUM_THREADS - 1);
      tid_valid <= 1'b0;
    end else begin
      ready_q <= ready_next;
      if (!stall) begin
        tid_valid <= any;
        if (any) tid <= gnt_idx;
      end
    end
  end

  assign ready_mask = ready_q;

endmodule

// File: tb/tb_mt_thread_sched.sv
// Directed self-checking bench for mt_thread_sched with hand-computed issue sequences.
module tb_mt_thread_sched;
  import mt_pkg::*;

  logic                   clk;
  logic                   rst;
  logic [NUM_THREADS-1:0] thread_en;
  logic                   halt_req;
  tid_t                   halt_tid;
  logic                   wake_req;
  tid_t                   wake_tid;
  logic                   stall;
  tid_t                   tid;
  logic                   tid_valid;
  logic [NUM_THREADS-1:0] ready_mask;

  int checks   = 0;
  int failures = 0;

  mt_thread_sched dut (
    .clk       (clk),
    .rst       (rst),
    .thread_en (thread_en),
    .halt_req  (halt_req),
    .halt_tid  (halt_tid),
    .wake_req  (wake_req),
    .wake_tid  (wake_tid),
    .stall     (stall),
    .tid       (tid),
    .tid_valid (tid_valid),
    .ready_mask(ready_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input tid_t exp_tid, input logic exp_valid);
    checks++;
    assert (tid === exp_tid) else begin
      failures++;
      $error("[TB] FAIL %s tid observed=%0d expected=%0d", tag, tid, exp_tid);
    end
    checks++;
    assert (tid_valid === exp_valid) else begin
      failures++;
      $error("[TB] FAIL %s tid_valid observed=%0b expected=%0b", tag, tid_valid, exp_valid);
    end
  endtask

  task automatic check_mask(input string tag, input logic [NUM_THREADS-1:0] exp_mask);
    checks++;
    assert (ready_mask === exp_mask) else begin
      failures++;
      $error("[TB] FAIL %s ready_mask observed=%h expected=%h", tag, ready_mask, exp_mask);
    end
  endtask

  initial begin
    tid_t exp_seq[$];
    tid_t halt_seq[$];

    rst       = 1'b0;
    thread_en = 8'hFF;
    halt_req  = 1'b0;
    halt_tid  = '0;
    wake_req  = 1'b0;
    wake_tid  = '0;
    stall     = 1'b0;

    // Reset state, then free-running round robin over all eight threads.
    #12;
    check_out("reset", 3'd7, 1'b0);
    check_mask("reset_mask", 8'hFF);
    rst = 1'b1;
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    foreach (exp_seq[i]) begin
      tick();
      check_out($sformatf("rr_all_%0d", i), exp_seq[i], 1'b1);
    end

    // Sparse enable mask, then a single enabled thread re-issuing itself.
    thread_en = 8'b0000_0101;
    exp_seq = '{3'd2, 3'd0, 3'd2, 3'd0};
    foreach (exp_seq[i]) begin
      tick();
      check_out($sformatf("en05_%0d", i), exp_seq[i], 1'b1);
    end
    thread_en = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("en01_%0d", i), 3'd0, 1'b1);
    end

    // Halt thread 3 while tid=2, then wake it back into its slot.
    thread_en = 8'hFF;
    tick();
    check_out("pre_halt_1", 3'd1, 1'b1);
    tick();
    check_out("pre_halt_2", 3'd2, 1'b1);
    halt_req = 1'b1;
    halt_tid = 3'd3;
    exp_seq = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd4};
    foreach (exp_seq[i]) begin
      tick();
      halt_req = 1'b0;
      check_out($sformatf("skip3_%0d", i), exp_seq[i], 1'b1);
    end
    check_mask("halted3_mask", 8'hF7);
    wake_req = 1'b1;
    wake_tid = 3'd3;
    exp_seq = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    foreach (exp_seq[i]) begin
      tick();
      wake_req = 1'b0;
      check_out($sformatf("wake3_%0d", i), exp_seq[i], 1'b1);
    end
    check_mask("woken3_mask", 8'hFF);

    // Same-cycle halt and wake of thread 5: wake wins.
    halt_req = 1'b1;
    halt_tid = 3'd5;
    wake_req = 1'b1;
    wake_tid = 3'd5;
    tick();
    halt_req = 1'b0;
    wake_req = 1'b0;
    check_out("hw5_a", 3'd4, 1'b1);
    check_mask("hw5_mask", 8'hFF);
    tick();
    check_out("hw5_b", 3'd5, 1'b1);

    // Halt every thread one per cycle until nothing is eligible.
    halt_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    exp_seq  = '{3'd6, 3'd7, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
    foreach (halt_seq[i]) begin
      halt_req = 1'b1;
      halt_tid = halt_seq[i];
      tick();
      check_out($sformatf("halt_all_%0d", i), exp_seq[i], (i != 7));
    end
    halt_req = 1'b0;
    tick();
    check_out("all_halted_hold", 3'd7, 1'b0);
    check_mask("all_halted_mask", 8'h00);
    wake_req = 1'b1;
    wake_tid = 3'd5;
    tick();
    wake_req = 1'b0;
    check_out("wake5_first", 3'd5, 1'b1);
    tick();
    check_out("wake5_repeat1", 3'd5, 1'b1);
    tick();
    check_out("wake5_repeat2", 3'd5, 1'b1);

    // Asynchronous reset between edges restores everything without a clock.
    #2;
    rst = 1'b0;
    #1;
    check_out("async_reset_1", 3'd7, 1'b0);
    check_mask("async_reset_1_mask", 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    exp_seq = '{3'd0, 3'd1, 3'd2};
    foreach (exp_seq[i]) begin
      tick();
      check_out($sformatf("post_reset_%0d", i), exp_seq[i], 1'b1);
    end

    // Stall for three edges while thread 6 is halted; issue then resumes skipping 6.
    stall    = 1'b1;
    halt_req = 1'b1;
    halt_tid = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      halt_req = 1'b0;
      check_out($sformatf("stall_%0d", i), 3'd2, 1'b1);
    end
    check_mask("stall_mask", 8'hBF);
    stall = 1'b0;
    exp_seq = '{3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
    foreach (exp_seq[i]) begin
      tick();
      check_out($sformatf("after_stall_%0d", i), exp_seq[i], 1'b1);
    end

    #2;
    rst = 1'b0;
    #1;
    check_out("async_reset_2", 3'd7, 1'b0);
    check_mask("async_reset_2_mask", 8'hFF);
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
